semaforo_request_ctrl: RTL and testbench

Pedestrian-request front end for the traffic-light controller `semaforo`. It debounces a raw push-button and enforces a minimum interval between light changes, using the millisecond count from `chronometer`. It issues a single-cycle `CHANGE` pulse to the light controller, then waits for the light controller to acknowledge by leaving green. It is the initiator side of the `CHANGE`/light-state handshake and sits between the board GPIO and `semaforo`.

---
 rtl/semaforo_request_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_semaforo_request_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_request_ctrl.sv
// semaforo_request_ctrl: pedestrian-request front end for the semaforo light
// controller. Debounces the raw button, enforces a minimum interval between
// light changes using the chronometer ms count, issues a one-cycle CHANGE
// pulse and waits for the light controller to leave green.
module semaforo_request_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 60000,
   parameter int unsigned MIN_GAP_MS      = 5000,
   parameter int unsigned ACK_TIMEOUT_MS  = 10000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EN,
   input  logic        BUTTON,
   input  logic [31:0] CHRONO,
   input  logic        GREEN,
   input  logic        YELLOW,
   input  logic        RED,
   output logic        CHANGE,
   output logic        PENDING,
   output logic        FAULT
);

   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [31:0]     GAP_MS  = 32'(MIN_GAP_MS);
   localparam logic [31:0]     ACK_MS  = 32'(ACK_TIMEOUT_MS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_WAIT_ACK = 2'd3
   } state_t;

   logic            btn_s1_r;
   logic            btn_s2_r;
   logic            green_s1_r;
   logic            green_s2_r;
   logic [1:0]      yr_s1_r;
   logic [1:0]      yr_status_unused_r;
   logic [31:0]     chrono_s1_r;
   logic [31:0]     chrono_s2_r;
   logic [31:0]     chrono_q_r;
   logic [DB_W-1:0] db_cnt_r;
   logic            deb_level_r;
   logic            deb_prev_r;
   state_t          state_r;
   logic            change_r;
   logic            pending_r;
   logic            fault_r;
   logic            first_r;
   logic [31:0]     last_change_r;
   logic [31:0]     t0_r;

   logic            press_s;
   logic [31:0]     since_last_s;
   logic [31:0]     since_t0_s;
   logic            gap_ok_s;
   logic            timeout_s;

   // Two-flop synchronisers for the button and the light-state inputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         btn_s1_r           <= 1'b0;
         btn_s2_r           <= 1'b0;
         green_s1_r         <= 1'b0;
         green_s2_r         <= 1'b0;
         yr_s1_r            <= 2'b00;
         yr_status_unused_r <= 2'b00;
      end else begin
         btn_s1_r           <= BUTTON;
         btn_s2_r           <= btn_s1_r;
         green_s1_r         <= GREEN;
         green_s2_r         <= green_s1_r;
         yr_s1_r            <= {YELLOW, RED};
         yr_status_unused_r <= yr_s1_r;
      end
   end

   // Multi-bit chronometer capture: only accept a value seen twice in a row
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         chrono_s1_r <= 32'h0000_0000;
         chrono_s2_r <= 32'h0000_0000;
         chrono_q_r  <= 32'h0000_0000;
      end else begin
         chrono_s1_r <= CHRONO;
         chrono_s2_r <= chrono_s1_r;
         if (chrono_s1_r == chrono_s2_r) begin
            chrono_q_r <= chrono_s2_r;
         end
      end
   end

   // Debounce: a new level must persist for DEBOUNCE_CYCLES samples to be taken
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         db_cnt_r    <= DB_ZERO;
         deb_level_r <= 1'b0;
         deb_prev_r  <= 1'b0;
      end else begin
         deb_prev_r <= deb_level_r;
         if (btn_s2_r == deb_level_r) begin
            db_cnt_r <= DB_ZERO;
         end else if (db_cnt_r == DB_LAST) begin
            deb_level_r <= btn_s2_r;
            db_cnt_r    <= DB_ZERO;
         end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
         end
      end
   end

   // Press edge detect and wrap-transparent elapsed-time comparisons
   always_comb begin
      press_s      = deb_level_r & ~deb_prev_r;
      since_last_s = chrono_q_r - last_change_r;
      since_t0_s   = chrono_q_r - t0_r;
      gap_ok_s     = first_r | (since_last_s >= GAP_MS);
      timeout_s    = (since_t0_s >= ACK_MS);
   end

   // Request sequencer: arm on press, pulse CHANGE once, wait for green to drop
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r       <= ST_IDLE;
         change_r      <= 1'b0;
         pending_r     <= 1'b0;
         fault_r       <= 1'b0;
         first_r       <= 1'b1;
         last_change_r <= 32'h0000_0000;
         t0_r          <= 32'h0000_0000;
      end else begin
         change_r <= 1'b0;
         if (!EN) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (press_s) begin
                     state_r   <= ST_ARMED;
                     pending_r <= 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (green_s2_r && gap_ok_s) begin
                     state_r  <= ST_ISSUE;
                     change_r <= 1'b1;
                  end
               end
               ST_ISSUE: begin
                  t0_r    <= chrono_q_r;
                  state_r <= ST_WAIT_ACK;
               end
               ST_WAIT_ACK: begin
                  // Acknowledge has priority over a simultaneous timeout
                  if (!green_s2_r) begin
                     last_change_r <= chrono_q_r;
                     first_r       <= 1'b0;
                     pending_r     <= 1'b0;
                     state_r       <= ST_IDLE;
                  end else if (timeout_s) begin
                     fault_r       <= 1'b1;
                     last_change_r <= chrono_q_r;
                     first_r       <= 1'b0;
                     pending_r     <= 1'b0;
                     state_r       <= ST_IDLE;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  pending_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign CHANGE  = change_r;
   assign PENDING = pending_r;
   assign FAULT   = fault_r;

endmodule

// File: tb/tb_semaforo_request_ctrl.sv
// Testbench for semaforo_request_ctrl with small timing parameters.
// Expectations come from the request rules: debounce latency, gap and
// timeout thresholds computed with 32-bit modular arithmetic.
module tb_semaforo_request_ctrl;

   localparam int DB  = 4;
   localparam int GAP = 5;
   localparam int TO  = 8;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        en     = 1'b1;
   logic        button = 1'b0;
   logic [31:0] chrono = 32'd0;
   logic        green  = 1'b1;
   logic        yellow = 1'b0;
   logic        red    = 1'b0;
   logic        change;
   logic        pending;
   logic        fault;

   int checks = 0;
   int errors = 0;

   // Observation counters updated on the falling edge
   int   change_count  = 0;
   int   pending_rises = 0;
   int   long_pulses   = 0;
   logic change_d      = 1'b0;
   logic pending_d     = 1'b0;

   // Time of the most recent acknowledged/timed-out change, as the bench knows it
   logic [31:0] prev_last = 32'd0;

   semaforo_request_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .MIN_GAP_MS     (GAP),
      .ACK_TIMEOUT_MS (TO)
   ) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .EN     (en),
      .BUTTON (button),
      .CHRONO (chrono),
      .GREEN  (green),
      .YELLOW (yellow),
      .RED    (red),
      .CHANGE (change),
      .PENDING(pending),
      .FAULT  (fault)
   );

   always #5 clk = ~clk;

   // Count CHANGE pulses, over-long pulses and PENDING rising edges
   always @(negedge clk) begin
      if (change === 1'b1) change_count <= change_count + 1;
      if (change === 1'b1 && change_d === 1'b1) long_pulses <= long_pulses + 1;
      if (pending === 1'b1 && pending_d !== 1'b1) pending_rises <= pending_rises + 1;
      change_d  <= change;
      pending_d <= pending;
   end

   // One clock: advance past the rising edge, then jiggle the status-only lights
   task automatic step();
      @(posedge clk);
      #1;
      yellow = 1'($urandom_range(0, 1));
      red    = 1'($urandom_range(0, 1));
   endtask

   // Clean button press long enough to debounce, then a clean release
   task automatic press_button();
      button = 1'b1;
      repeat (12) step();
      button = 1'b0;
      repeat (8) step();
   endtask

   // Light controller leaves green, then returns to green
   task automatic acknowledge();
      green = 1'b0;
      repeat (5) step();
      green = 1'b1;
      repeat (5) step();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      button = 1'b1;
      en     = 1'b1;
      green  = 1'b1;
      chrono = 32'd0;
      repeat (3) step();
      checks++;
      if ({change, pending, fault} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000", {change, pending, fault});
      end
      button = 1'b0;
      rst_n  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if ({change, pending, fault} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle k=%0d: got %b expected 000", k, {change, pending, fault});
         end
      end
   endtask

   task automatic test_debounce();
      logic val;
      int   total;
      int   len;
      val   = 1'b1;
      total = 0;
      // Bounce with runs shorter than the debounce length, ending low
      forever begin
         len    = $urandom_range(1, DB - 1);
         button = val;
         for (int k = 0; k < len; k++) begin
            step();
            checks++;
            if (pending !== 1'b0 || change !== 1'b0) begin
               errors++;
               $display("FAIL bounce_quiet: got pending=%b change=%b expected 0 0", pending, change);
            end
         end
         total += len;
         if (total >= 20 && val == 1'b0) break;
         val = ~val;
      end
      // Hold: PENDING after 2 sync + DB + 1 edge cycles, CHANGE one cycle later
      button = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (pending !== (k >= 2 + DB + 1)) begin
            errors++;
            $display("FAIL debounce_pending k=%0d: got %b expected %b", k, pending, (k >= 2 + DB + 1));
         end
         checks++;
         if (change !== (k == 2 + DB + 2)) begin
            errors++;
            $display("FAIL debounce_change k=%0d: got %b expected %b", k, change, (k == 2 + DB + 2));
         end
      end
      // Acknowledge: PENDING drops on the third cycle after GREEN falls
      green = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if (pending !== (k < 3)) begin
            errors++;
            $display("FAIL ack_latency k=%0d: got %b expected %b", k, pending, (k < 3));
         end
      end
      // Button still held: no second request
      for (int k = 0; k < 15; k++) begin
         step();
         checks++;
         if (pending !== 1'b0) begin
            errors++;
            $display("FAIL held_button k=%0d: got %b expected 0", k, pending);
         end
      end
      button = 1'b0;
      green  = 1'b1;
      repeat (10) step();
      prev_last = chrono;
   endtask

   // Acknowledge at base, press at base+d: CHANGE exactly once, when elapsed reaches max(d,GAP)
   task automatic test_min_gap(input logic [31:0] base_in, input int d);
      logic [31:0] base;
      int          c;
      int          exp_at;
      int          exp_n;
      base = base_in;
      if ((base - prev_last) < 32'd16) base = prev_last + 32'd100;
      exp_at = (d > GAP) ? d : GAP;
      chrono = base;
      repeat (5) step();
      c = change_count;
      press_button();
      checks++;
      if (change_count - c !== 1) begin
         errors++;
         $display("FAIL gap_setup_change base=%0h: got %0d expected 1", base, change_count - c);
      end
      acknowledge();
      checks++;
      if (pending !== 1'b0) begin
         errors++;
         $display("FAIL gap_setup_ack base=%0h: got %b expected 0", base, pending);
      end
      for (int v = d; v <= 8; v++) begin
         chrono = base + 32'(v);
         c      = change_count;
         if (v == d) begin
            repeat (3) step();
            press_button();
            checks++;
            if (pending !== 1'b1) begin
               errors++;
               $display("FAIL gap_pending base=%0h d=%0d: got %b expected 1", base, d, pending);
            end
         end else begin
            repeat (10) step();
         end
         exp_n = (v == exp_at) ? 1 : 0;
         checks++;
         if (change_count - c !== exp_n) begin
            errors++;
            $display("FAIL gap_pulses base=%0h v=%0d: got %0d expected %0d", base, v, change_count - c, exp_n);
         end
      end
      acknowledge();
      prev_last = base + 32'd8;
      checks++;
      if (pending !== 1'b0) begin
         errors++;
         $display("FAIL gap_final_ack base=%0h: got %b expected 0", base, pending);
      end
   endtask

   task automatic test_timeout(input logic [31:0] base_in);
      logic [31:0] base;
      int          c;
      base = base_in;
      if ((base - prev_last) < 32'd16) base = prev_last + 32'd100;
      chrono = base;
      repeat (5) step();
      c = change_count;
      press_button();
      checks++;
      if (change_count - c !== 1) begin
         errors++;
         $display("FAIL timeout_change: got %0d expected 1", change_count - c);
      end
      for (int v = 1; v <= 8; v++) begin
         chrono = base + 32'(v);
         repeat (10) step();
         checks++;
         if (fault !== (v >= TO)) begin
            errors++;
            $display("FAIL timeout_fault v=%0d: got %b expected %b", v, fault, (v >= TO));
         end
         checks++;
         if (pending !== (v < TO)) begin
            errors++;
            $display("FAIL timeout_pending v=%0d: got %b expected %b", v, pending, (v < TO));
         end
      end
      prev_last = base + 32'd8;
      // A later successful request leaves FAULT set
      chrono = base + 32'd30;
      repeat (5) step();
      c = change_count;
      press_button();
      checks++;
      if (change_count - c !== 1) begin
         errors++;
         $display("FAIL after_fault_change: got %0d expected 1", change_count - c);
      end
      acknowledge();
      prev_last = base + 32'd30;
      checks++;
      if (fault !== 1'b1 || pending !== 1'b0) begin
         errors++;
         $display("FAIL fault_sticky: got fault=%b pending=%b expected 1 0", fault, pending);
      end
   endtask

   task automatic test_random_gap();
      for (int i = 0; i < 4; i++) begin
         test_min_gap($urandom, $urandom_range(0, 7));
      end
   endtask

   task automatic test_enable_drop();
      logic [31:0] cb;
      int          c0;
      int          r0;
      cb     = prev_last + 32'd40;
      chrono = cb;
      repeat (5) step();
      press_button();
      acknowledge();
      prev_last = cb;
      // Second press at the same ms: gap closed, stays armed
      r0 = pending_rises;
      c0 = change_count;
      press_button();
      checks++;
      if (pending !== 1'b1 || pending_rises - r0 !== 1 || change_count - c0 !== 0) begin
         errors++;
         $display("FAIL armed_hold: got pending=%b rises=%0d changes=%0d expected 1 1 0",
                  pending, pending_rises - r0, change_count - c0);
      end
      en = 1'b0;
      step();
      checks++;
      if (pending !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_pending: got %b expected 0", pending);
      end
      chrono = cb + 32'd20;
      repeat (10) step();
      press_button();
      checks++;
      if (pending !== 1'b0 || pending_rises - r0 !== 1 || change_count - c0 !== 0) begin
         errors++;
         $display("FAIL en_low_press: got pending=%b rises=%0d changes=%0d expected 0 1 0",
                  pending, pending_rises - r0, change_count - c0);
      end
      en = 1'b1;
      repeat (10) step();
      checks++;
      if (pending !== 1'b0 || change_count - c0 !== 0) begin
         errors++;
         $display("FAIL en_restore: got pending=%b changes=%0d expected 0 0", pending, change_count - c0);
      end
   endtask

   task automatic test_reset_clears_fault();
      checks++;
      if (fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_before_reset: got %b expected 1", fault);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({change, pending, fault} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: got %b expected 000", {change, pending, fault});
      end
      repeat (3) step();
      rst_n = 1'b1;
      repeat (5) step();
      checks++;
      if ({change, pending, fault} !== 3'b000) begin
         errors++;
         $display("FAIL after_reset: got %b expected 000", {change, pending, fault});
      end
      checks++;
      if (long_pulses !== 0) begin
         errors++;
         $display("FAIL change_width: got %0d long pulses expected 0", long_pulses);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_min_gap(32'd100, 2);
      test_timeout(32'd200);
      test_min_gap(32'hFFFF_FFFE, 2);
      test_random_gap();
      test_enable_drop();
      test_reset_clears_fault();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
